// File: rtl/spart_driver_if.sv
// SPART processor-side bus signals (everything except the bidirectional databus).
//
// Bus protocol: a write cycle is any cycle with iocs=1 and iorw=0; the SPART
// samples ioaddr/databus during that cycle, and each write lasts one cycle.
// With iocs=0 and iorw=1 the bus is idle and the SPART drives its receive byte
// onto databus while rda=1. rda is a one-cycle pulse. tbr is a level that the
// SPART deasserts one registered cycle after it accepts a transmit byte.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor after reset and on every br_cfg
// change, then echoes received bytes back out through a small FIFO.
module spart_driver #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic           cfg_done,
  output logic           rx_overrun,
  output logic [7:0]     last_char,
  output logic [1:0]     dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {CFG_LO = 2'd0, CFG_HI = 2'd1, RUN = 2'd2} state_t;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   divisor = 16'(CLK_HZ / 4800);
      2'b01:   divisor = 16'(CLK_HZ / 9600);
      2'b10:   divisor = 16'(CLK_HZ / 19200);
      default: divisor = 16'(CLK_HZ / 38400);
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          iocs_q, iocs_d;
  logic          iorw_q, iorw_d;
  logic [1:0]    ioaddr_q, ioaddr_d;
  logic          db_oe_q, db_oe_d;
  logic [7:0]    db_out_q, db_out_d;
  logic          wr_d1_q, wr_d1_d;
  logic [1:0]    cfg_reg_q, cfg_reg_d;
  logic          cfg_done_q, cfg_done_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic [7:0]    last_char_q, last_char_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          fifo_empty, fifo_full, capture, reconfig, tx_go;
  logic [1:0]    div_sel;
  logic [15:0]   div_val;

  assign databus    = db_oe_q ? db_out_q : 8'hzz;
  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign cfg_done   = cfg_done_q;
  assign rx_overrun = rx_overrun_q;
  assign last_char  = last_char_q;
  assign dbg_state  = state_q;

  // Next-state, registered bus outputs, receive capture and FIFO update.
  always_comb begin
    state_d      = state_q;
    iocs_d       = 1'b0;
    iorw_d       = 1'b1;
    ioaddr_d     = 2'b00;
    db_oe_d      = 1'b0;
    db_out_d     = 8'h00;
    wr_d1_d      = iocs_q;
    cfg_reg_d    = cfg_reg_q;
    cfg_done_d   = 1'b0;
    rx_overrun_d = rx_overrun_q;
    last_char_d  = last_char_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    tx_go        = 1'b0;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // The receive byte is only on the bus while we are not driving a write.
    capture    = bus.rda && !iocs_q;
    reconfig   = (br_cfg != cfg_reg_q);
    div_sel    = (state_q == CFG_LO) ? br_cfg : cfg_reg_q;
    div_val    = divisor(div_sel);

    if (bus.rda) begin
      if (iocs_q) begin
        rx_overrun_d = 1'b1;
      end else begin
        last_char_d = databus;
        if (fifo_full) rx_overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      CFG_LO: begin
        iocs_d    = 1'b1;
        iorw_d    = 1'b0;
        ioaddr_d  = 2'b10;
        db_oe_d   = 1'b1;
        db_out_d  = div_val[7:0];
        cfg_reg_d = br_cfg;
        state_d   = CFG_HI;
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b11;
        db_oe_d  = 1'b1;
        db_out_d = div_val[15:8];
        state_d  = RUN;
      end
      RUN: begin
        if (reconfig) begin
          // Any write on the bus now completes this cycle on its own.
          state_d = CFG_LO;
        end else begin
          cfg_done_d = 1'b1;
          // Cooldown: no write this cycle or last, so tbr has had time to fall.
          tx_go = bus.tbr && !iocs_q && !wr_d1_q && (!fifo_empty || capture);
        end
      end
      default: state_d = CFG_LO;
    endcase

    if (tx_go) begin
      iocs_d   = 1'b1;
      iorw_d   = 1'b0;
      ioaddr_d = 2'b00;
      db_oe_d  = 1'b1;
      // Empty FIFO: forward the byte being captured this cycle directly.
      db_out_d = fifo_empty ? databus : mem_q[rd_ptr_q[AW-1:0]];
      if (!fifo_empty) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (capture && !fifo_full && !(tx_go && fifo_empty)) begin
      mem_d[wr_ptr_q[AW-1:0]] = databus;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CFG_LO;
      iocs_q       <= 1'b0;
      iorw_q       <= 1'b1;
      ioaddr_q     <= 2'b00;
      db_oe_q      <= 1'b0;
      db_out_q     <= 8'h00;
      wr_d1_q      <= 1'b0;
      cfg_reg_q    <= 2'b00;
      cfg_done_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      last_char_q  <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      iocs_q       <= iocs_d;
      iorw_q       <= iorw_d;
      ioaddr_q     <= ioaddr_d;
      db_oe_q      <= db_oe_d;
      db_out_q     <= db_out_d;
      wr_d1_q      <= wr_d1_d;
      cfg_reg_q    <= cfg_reg_d;
      cfg_done_q   <= cfg_done_d;
      rx_overrun_q <= rx_overrun_d;
      last_char_q  <= last_char_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_spart_driver.sv
// Testbench for spart_driver: SPART bus model, table-driven config and echo
// vectors, and hand-written overrun / reconfiguration / reset sequences.
module tb_spart_driver;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0] br;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] exp_last;
    logic [9:0] exp_wr;
  } echo_vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       cfg_done, rx_overrun;
  logic [7:0] last_char;
  logic [1:0] dbg_state;
  wire  [7:0] databus;

  always #5 clk = ~clk;

  spart_driver_if bus_if();

  // ---------------- SPART model ----------------
  logic [7:0] rx_byte;
  logic       tbr_hold;
  int         tbr_cool = 0;
  int         cyc = 0;
  int         last_wr_cyc = -100;

  assign databus    = (bus_if.rda && !bus_if.iocs) ? rx_byte : 8'hzz;
  assign bus_if.tbr = !tbr_hold && (tbr_cool == 0);

  spart_driver #(.CLK_HZ(50_000_000), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .bus        (bus_if.master),
    .databus    (databus),
    .cfg_done   (cfg_done),
    .rx_overrun (rx_overrun),
    .last_char  (last_char),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus monitor: log every write, enforce transmit spacing, model tbr drop.
  always @(negedge clk) begin
    cyc++;
    if (tbr_cool > 0) tbr_cool--;
    if (rst && bus_if.iocs && !bus_if.iorw) begin
      obs_q.push_back({bus_if.ioaddr, databus});
      if (bus_if.ioaddr == 2'b00) begin
        checks++;
        if (cyc - last_wr_cyc < 3) begin
          errors++;
          $display("FAIL write_spacing: got gap %0d expected >=3", cyc - last_wr_cyc);
        end
        tbr_cool = 10;
      end
      last_wr_cyc = cyc;
    end
  end

  task automatic drain(input string name);
    logic [9:0] e, a;
    check({name, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 10'bx;
      check(name, {6'd0, a}, {6'd0, e});
    end
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte    = b;
    bus_if.rda = 1'b1;
    step(1);
    bus_if.rda = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] br, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    rst        = 1'b0;
    br_cfg     = br;
    bus_if.rda = 1'b0;
    step(12);
    check("rst_iocs", 16'(bus_if.iocs), 16'd0);
    check("rst_iorw", 16'(bus_if.iorw), 16'd1);
    check("rst_ioaddr", 16'(bus_if.ioaddr), 16'd0);
    check("rst_databus", 16'(databus), 16'(8'hzz));
    check("rst_cfg_done", 16'(cfg_done), 16'd0);
    check("rst_overrun", 16'(rx_overrun), 16'd0);
    check("rst_last_char", 16'(last_char), 16'd0);
    check("rst_state", 16'(dbg_state), 16'd0);
    rst = 1'b1;
    step(1);
    check("cfg_lo_iocs", 16'(bus_if.iocs), 16'd1);
    check("cfg_lo_iorw", 16'(bus_if.iorw), 16'd0);
    check("cfg_lo_addr", 16'(bus_if.ioaddr), 16'd2);
    check("cfg_lo_data", 16'(databus), 16'(lo));
    check("cfg_lo_done", 16'(cfg_done), 16'd0);
    step(1);
    check("cfg_hi_iocs", 16'(bus_if.iocs), 16'd1);
    check("cfg_hi_addr", 16'(bus_if.ioaddr), 16'd3);
    check("cfg_hi_data", 16'(databus), 16'(hi));
    check("cfg_hi_done", 16'(cfg_done), 16'd0);
    step(1);
    check("cfg_done_set", 16'(cfg_done), 16'd1);
    check("cfg_idle_iocs", 16'(bus_if.iocs), 16'd0);
    check("cfg_run_state", 16'(dbg_state), 16'd2);
    obs_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    cfg_vec_t  cfg_tab[4];
    echo_vec_t echo_tab[4];
    int        n;

    cfg_tab[0] = '{br: 2'b00, lo: 8'hB0, hi: 8'h28};
    cfg_tab[1] = '{br: 2'b10, lo: 8'h2C, hi: 8'h0A};
    cfg_tab[2] = '{br: 2'b11, lo: 8'h16, hi: 8'h05};
    cfg_tab[3] = '{br: 2'b01, lo: 8'h58, hi: 8'h14};

    echo_tab[0] = '{rx: 8'h41, exp_last: 8'h41, exp_wr: {2'b00, 8'h41}};
    echo_tab[1] = '{rx: 8'h00, exp_last: 8'h00, exp_wr: {2'b00, 8'h00}};
    echo_tab[2] = '{rx: 8'hFF, exp_last: 8'hFF, exp_wr: {2'b00, 8'hFF}};
    echo_tab[3] = '{rx: 8'hA5, exp_last: 8'hA5, exp_wr: {2'b00, 8'hA5}};

    rst        = 1'b0;
    br_cfg     = 2'b01;
    bus_if.rda = 1'b0;
    rx_byte    = 8'h00;
    tbr_hold   = 1'b0;

    // Divisor programming for every baud setting (last one leaves 9600).
    for (int i = 0; i < 4; i++) do_reset(cfg_tab[i].br, cfg_tab[i].lo, cfg_tab[i].hi);

    // Single-byte echo with an empty FIFO and tbr high: write one cycle later.
    for (int i = 0; i < 4; i++) begin
      step(15);
      obs_q.delete();
      pulse_rx(echo_tab[i].rx);
      check("echo_last_char", 16'(last_char), 16'(echo_tab[i].exp_last));
      check("echo_iocs", 16'(bus_if.iocs), 16'd1);
      check("echo_iorw", 16'(bus_if.iorw), 16'd0);
      check("echo_addr", 16'(bus_if.ioaddr), 16'd0);
      check("echo_data", 16'(databus), 16'(echo_tab[i].exp_wr[7:0]));
      step(14);
      exp_q.push_back(echo_tab[i].exp_wr);
      drain("echo_once");
    end

    // Fill the FIFO with tbr held low; the fifth byte overruns.
    tbr_hold = 1'b1;
    step(2);
    obs_q.delete();
    for (int i = 1; i <= 5; i++) begin
      pulse_rx(8'(i));
      if (i == 4) check("fill_no_overrun", 16'(rx_overrun), 16'd0);
      if (i == 5) check("fill_overrun", 16'(rx_overrun), 16'd1);
      step(1);
    end
    check("fill_last_char", 16'(last_char), 16'h05);
    check("fill_no_writes", 16'(obs_q.size()), 16'd0);
    for (int i = 1; i <= 4; i++) exp_q.push_back({2'b00, 8'(i)});
    tbr_hold = 1'b0;
    step(60);
    drain("fill_echo");

    // Reconfiguration 9600 -> 38400 with two bytes queued.
    tbr_hold = 1'b1;
    pulse_rx(8'h0A);
    step(1);
    pulse_rx(8'h0B);
    step(1);
    obs_q.delete();
    br_cfg   = 2'b11;
    tbr_hold = 1'b0;
    step(1);
    check("reconf_done_drop", 16'(cfg_done), 16'd0);
    n = 0;
    while (!cfg_done && n < 20) begin
      step(1);
      n++;
    end
    check("reconf_done_back", 16'(cfg_done), 16'd1);
    exp_q.push_back({2'b10, 8'h16});
    exp_q.push_back({2'b11, 8'h05});
    exp_q.push_back({2'b00, 8'h0A});
    exp_q.push_back({2'b00, 8'h0B});
    step(40);
    drain("reconf_seq");

    // rda during a transmit write: byte invisible, overrun set, last_char kept.
    do_reset(2'b01, 8'h58, 8'h14);
    step(10);
    pulse_rx(8'h33);
    check("collide_write", 16'(bus_if.iocs), 16'd1);
    check("collide_pre_overrun", 16'(rx_overrun), 16'd0);
    rx_byte    = 8'h77;
    bus_if.rda = 1'b1;
    step(1);
    bus_if.rda = 1'b0;
    check("collide_overrun", 16'(rx_overrun), 16'd1);
    check("collide_last_char", 16'(last_char), 16'h33);
    exp_q.push_back({2'b00, 8'h33});
    step(20);
    drain("collide_seq");

    // Asynchronous reset with three bytes queued: nothing stale is echoed.
    tbr_hold = 1'b1;
    pulse_rx(8'h61);
    step(1);
    pulse_rx(8'h62);
    step(1);
    pulse_rx(8'h63);
    step(1);
    check("pre_rst_last_char", 16'(last_char), 16'h63);
    check("pre_rst_cfg_done", 16'(cfg_done), 16'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_cfg_done", 16'(cfg_done), 16'd0);
    check("async_rst_last_char", 16'(last_char), 16'd0);
    check("async_rst_iorw", 16'(bus_if.iorw), 16'd1);
    check("async_rst_state", 16'(dbg_state), 16'd0);
    @(negedge clk);
    obs_q.delete();
    rst      = 1'b1;
    tbr_hold = 1'b0;
    exp_q.push_back({2'b10, 8'h58});
    exp_q.push_back({2'b11, 8'h14});
    step(40);
    drain("post_rst_seq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spart_driver.md
# spart_driver

Processor-side driver for the SPART serial port in the Minilab3 loopback design. It sits directly upstream of the SPART on its bus (iocs/iorw/ioaddr/databus, with rda/tbr as status). On reset, and whenever the baud switch setting changes, it programs the SPART baud divisor. It then echoes every received byte back out through a small FIFO, which decouples receive pulses from transmitter availability.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; divisor = CLK_HZ / baud, truncated.
- DEPTH, 4: echo FIFO depth in bytes; power of two, at least 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- br_cfg  in  2  baud select: 00→4800, 01→9600, 10→19200, 11→38400.
- rda  in  1  SPART receive-data-available; one-cycle pulse.
- tbr  in  1  SPART transmit-buffer-ready; level.
- iocs  out  1  SPART chip select.
- iorw  out  1  1 = read, 0 = write.
- ioaddr  out  2  00 = tx/rx buffer, 10 = divisor low byte, 11 = divisor high byte.
- databus  inout  8  driven only during write cycles; high-Z otherwise.
- cfg_done  out  1  high once the divisor for the current br_cfg has been written.
- rx_overrun  out  1  sticky; set when a received byte is lost.
- last_char  out  8  most recent byte captured from the SPART.

## Operation
- All bus-control outputs (iocs, iorw, ioaddr) and the databus drive enable/value are registered.
- Idle bus posture: iocs=0, iorw=1, ioaddr=00, databus high-Z. In this posture the SPART presents its receive byte whenever rda=1.
- States: CFG_LO, CFG_HI, RUN.
- CFG_LO
  - Drives one write cycle: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0].
  - Latches br_cfg into cfg_reg.
  - Next state: CFG_HI.
- CFG_HI
  - Drives one write cycle: ioaddr=11, databus=divisor[15:8].
  - Next state: RUN; cfg_done←1.
- Divisor values at the default CLK_HZ:
  - 4800: 10416 (0x28B0)
  - 9600: 5208 (0x1458)
  - 19200: 2604 (0x0A2C)
  - 38400: 1302 (0x0516)
- RUN, receive: in any cycle where the bus is in idle posture and rda=1, capture databus.
  - last_char←byte.
  - Push the byte to the FIFO if it is not full; otherwise drop it and set rx_overrun←1.
- RUN, transmit
  - Condition: tbr=1, FIFO not empty, no write issued in the previous two cycles, and no reconfiguration pending.
  - Action: pop the FIFO head and drive one write cycle (iocs=1, iorw=0, ioaddr=00, databus=byte).
  - The two-cycle cooldown covers the SPART's registered tbr deassertion.
- rda arriving during any write cycle (config or transmit): the byte is not visible, so set rx_overrun←1.
- Reconfiguration
  - Trigger: in RUN, br_cfg≠cfg_reg, sampled every cycle.
  - Set cfg_done←0.
  - Finish any write currently in flight, then go to CFG_LO.
  - FIFO contents are retained and echoed after reconfiguration completes.
- FIFO
  - Circular buffer with log2(DEPTH)+1-bit pointers, so full and empty are distinguishable.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push when full is ignored. Pop when empty never occurs.

## Timing
- Reset values: iocs=0, iorw=1, ioaddr=00, databus Z, cfg_done=0, rx_overrun=0, last_char=00, FIFO empty, state CFG_LO.
- After rst deasserts:
  - CFG_LO write during cycle 1.
  - CFG_HI write during cycle 2.
  - cfg_done=1 from cycle 3.
- Capture latency: a byte present with rda=1 in cycle n appears on last_char and in the FIFO at the edge ending cycle n.
- Echo latency, empty FIFO and tbr=1: rda in cycle n → write cycle n+1 at the earliest.
- Only one bus write per cycle. Writes are at least 3 cycles apart.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously), the FIFO is flushed, and configuration restarts on release.

## Test plan
- Reset release with br_cfg=01 → write 0x58 to ioaddr 10, then write 0x14 to ioaddr 11 on the following cycle; cfg_done=1 from the third cycle.
- RUN, tbr=1, rda pulse with databus=0x41 → last_char=0x41; exactly one write of 0x41 to ioaddr 00, one cycle later.
- Hold tbr=0; pulse rda with bytes 0x01–0x05, DEPTH=4 → first four buffered, rx_overrun=1. Release tbr (model drops it for 10 cycles after each write) → 0x01, 0x02, 0x03, 0x04 echoed in order; 0x05 never sent.
- Change br_cfg 01→11 in RUN → cfg_done drops; writes 0x16 to ioaddr 10, then 0x05 to ioaddr 11; cfg_done returns to 1; queued bytes echo afterwards.
- rda pulse in the same cycle as a transmit write → byte not captured, rx_overrun=1, last_char unchanged.
- Assert rst while the FIFO holds 3 bytes → outputs reset immediately; after release, only the configuration writes occur and no stale bytes are echoed.
